// File: rtl/aes_128_req_arbiter.sv
// Round-robin arbiter sharing one in-order AES-128 core among N_REQ requesters.
// An in-flight tag FIFO routes each core result back to the requester that issued it.
//
// state | meaning
// IDLE  | waiting for a grant (core ready, tag FIFO not full, a request valid)
// ISSUE | core_in_en pulse; tag pushed into the in-flight FIFO
// HOLD  | dead cycle so core_key_ready can fall before the next grant
module aes_128_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 4,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*128-1:0] req_data,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 core_key_ready,
  output logic                 core_in_en,
  output logic [127:0]         core_in_data,
  input  logic                 core_out_en,
  input  logic [127:0]         core_out_data,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [127:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic                 orphan_irq_pulse
);

  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] tag_id;
  logic [ID_W-1:0] idx_l;
  logic            win_found;
  logic            grant;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [ID_W-1:0] tag_mem [TAG_DEPTH];
  int              idx;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = ID_W'(idx);
      if (!win_found && req_valid[idx_l]) begin
        win_found = 1'b1;
        win_id    = idx_l;
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign grant      = kill_n && (state == IDLE) && core_key_ready && !fifo_full && win_found;
  assign req_ready  = grant ? (N_REQ'(1) << win_id) : '0;
  assign push       = (state == ISSUE);
  assign pop        = core_out_en && !fifo_empty;
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      tag_id       <= '0;
      core_in_en   <= 1'b0;
      core_in_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_in_en <= 1'b0;
          if (grant) begin
            core_in_data <= req_data[128*win_id +: 128];
            tag_id       <= win_id;
            rr_ptr       <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
            core_in_en   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          core_in_en <= 1'b0;
          state      <= HOLD;
        end
        HOLD: begin
          core_in_en <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          core_in_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // A pop on an empty FIFO never happens; an empty-cycle result is an orphan
  // even if this same cycle pushes a tag.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr[AW-1:0]] <= tag_id;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      rsp_valid        <= '0;
      rsp_data         <= '0;
      rsp_id           <= '0;
      orphan_irq_pulse <= 1'b0;
    end else begin
      rsp_valid        <= pop ? (N_REQ'(1) << tag_mem[rd_ptr[AW-1:0]]) : '0;
      orphan_irq_pulse <= core_out_en && fifo_empty;
      if (pop) begin
        rsp_data <= core_out_data;
        rsp_id   <= tag_mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_aes_128_req_arbiter.sv
// Self-checking bench for aes_128_req_arbiter: cycle-level reference model plus
// directed scenarios with literal expectations.
module tb_aes_128_req_arbiter;
  localparam int N  = 4;
  localparam int TD = 4;

  logic           clk = 1'b0;
  logic           kill_n;
  logic [N-1:0]   req_valid;
  logic [N*128-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           core_key_ready;
  logic           core_in_en;
  logic [127:0]   core_in_data;
  logic           core_out_en;
  logic [127:0]   core_out_data;
  logic [N-1:0]   rsp_valid;
  logic [127:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
  logic           orphan_irq_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_128_req_arbiter #(.N_REQ(N), .TAG_DEPTH(TD), .ID_W(2)) dut (
    .clk(clk), .kill_n(kill_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .core_key_ready(core_key_ready), .core_in_en(core_in_en),
    .core_in_data(core_in_data), .core_out_en(core_out_en), .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
    .orphan_irq_pulse(orphan_irq_pulse)
  );

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: grants at least 3 cycles apart, in-flight ids as a queue.
  int           m_cyc, m_last_g, m_rr, m_gid, m_pid, gap, e_w, idx;
  logic [127:0] m_gdata, m_pdata;
  bit           m_prsp, m_porph;
  int           m_q[$];
  logic [N-1:0] e_rdy;

  task automatic model_reset();
    m_cyc = 0; m_last_g = -100; m_rr = 0; m_gid = 0; m_pid = 0;
    m_gdata = '0; m_pdata = '0; m_prsp = 0; m_porph = 0;
    m_q.delete();
  endtask

  always @(negedge clk) begin
    if (!kill_n) begin
      cmp("reset_outputs", {req_ready, core_in_en, rsp_valid, busy, orphan_irq_pulse}, '0);
      model_reset();
    end else begin
      gap   = m_cyc - m_last_g;
      e_w   = -1;
      e_rdy = '0;
      if (gap >= 3 && core_key_ready && m_q.size() < TD && req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (e_w < 0 && req_valid[idx]) e_w = idx;
        end
        e_rdy = N'(1) << e_w;
      end
      cmp("m_req_ready", req_ready, e_rdy);
      cmp("m_core_in_en", core_in_en, (gap == 1));
      cmp("m_core_in_data", core_in_data, m_gdata);
      cmp("m_rsp_valid", rsp_valid, m_prsp ? (N'(1) << m_pid) : '0);
      if (m_prsp) begin
        cmp("m_rsp_data", rsp_data, m_pdata);
        cmp("m_rsp_id", rsp_id, m_pid);
      end
      cmp("m_orphan", orphan_irq_pulse, m_porph);
      cmp("m_busy", busy, (gap == 1 || gap == 2 || m_q.size() != 0));
      m_porph = core_out_en && (m_q.size() == 0);
      m_prsp  = core_out_en && (m_q.size() != 0);
      if (m_prsp) begin
        m_pid   = m_q.pop_front();
        m_pdata = core_out_data;
      end
      if (gap == 1) m_q.push_back(m_gid);
      if (e_w >= 0) begin
        m_last_g = m_cyc;
        m_gid    = e_w;
        m_gdata  = req_data[128*e_w +: 128];
        m_rr     = (e_w + 1) % N;
      end
      m_cyc++;
    end
  end

  localparam logic [127:0] D2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R2 = 128'hfeedface_0badf00d_12345678_9abcdef0;

  int  gid[$];
  int  gcyc[$];
  int  iss[$];
  int  exp_order[5] = '{0, 1, 2, 3, 0};
  int  exp_drain[4] = '{3, 0, 1, 2};
  bit  prev_en;
  int  ngrant;

  initial begin
    kill_n = 1'b0; req_valid = '0; core_key_ready = 1'b0;
    core_out_en = 1'b0; core_out_data = '0;
    for (int i = 0; i < N; i++) req_data[128*i +: 128] = {4{32'hC0DE0000 + 32'(i)}};
    req_data[128 +: 128] = D2;
    #2;
    cmp("reset_state", {req_ready, core_in_en, rsp_valid, busy, orphan_irq_pulse, core_in_data}, '0);
    repeat (2) @(posedge clk);
    #1 kill_n = 1'b1;

    // single request on channel 1
    tick(); req_valid = 4'b0010; core_key_ready = 1'b1;
    @(negedge clk); cmp("t2_req_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    @(negedge clk); cmp("t2_in_en", core_in_en, 1'b1); cmp("t2_in_data", core_in_data, D2);
    tick(); tick(); core_out_en = 1'b1; core_out_data = R2;
    tick(); core_out_en = 1'b0;
    @(negedge clk);
    cmp("t2_rsp_valid", rsp_valid, 4'b0010); cmp("t2_rsp_id", rsp_id, 2'd1);
    cmp("t2_rsp_data", rsp_data, R2);

    // reset while in ISSUE
    tick(); req_valid = 4'b0100;
    tick(); req_valid = 4'b0001;
    cmp("t1_pre_in_en", core_in_en, 1'b1);
    #2 kill_n = 1'b0;
    #1;
    cmp("t1_in_en", core_in_en, 1'b0); cmp("t1_req_ready", req_ready, '0);
    cmp("t1_rsp_valid", rsp_valid, '0); cmp("t1_busy", busy, 1'b0);
    req_valid = '0;
    tick(); kill_n = 1'b1;

    // fairness with all channels requesting; bench answers each issue next cycle
    tick(); req_valid = 4'hF; prev_en = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin gid.push_back(i); gcyc.push_back(c); end
      prev_en = core_in_en;
      tick(); core_out_en = prev_en; core_out_data = {4{32'(c) + 32'h55AA0000}};
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); prev_en = core_in_en;
      tick(); core_out_en = prev_en;
    end
    core_out_en = 1'b0;
    cmp("t3_grant_count", gid.size(), 6);
    if (gid.size() >= 5) begin
      cmp("t3_first_cycle", gcyc[0], 0);
      for (int k = 0; k < 5; k++) cmp($sformatf("t3_order%0d", k), gid[k], exp_order[k]);
      for (int k = 0; k < 4; k++) cmp($sformatf("t3_spacing%0d", k), gcyc[k+1] - gcyc[k], 3);
    end

    // FIFO full: four issues, no results -> no fifth grant
    tick(); req_valid = 4'hF; ngrant = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin ngrant++; iss.push_back(i); end
      tick();
    end
    cmp("t4_grants_when_full", ngrant, 4);
    cmp("t4_busy", busy, 1'b1);
    core_out_en = 1'b1; core_out_data = 128'h1;
    @(negedge clk); cmp("t4_no_grant_at_pop", req_ready, '0);
    tick(); core_out_en = 1'b0;
    @(negedge clk);
    cmp("t4_resume_grant", req_ready, 4'b0100);
    cmp("t4_rsp_first", rsp_id, 2'd2);
    if (iss.size() > 0) cmp("t4_rsp_first_vs_issue", rsp_id, iss[0]);
    tick(); req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      core_out_en = 1'b1; core_out_data = 128'(k + 16);
      tick(); core_out_en = 1'b0;
      @(negedge clk);
      cmp($sformatf("t4_rsp_order%0d", k), rsp_id, exp_drain[k]);
      tick();
    end

    // orphan with empty FIFO
    core_out_en = 1'b1;
    tick(); core_out_en = 1'b0;
    @(negedge clk); cmp("t5_orphan", orphan_irq_pulse, 1'b1); cmp("t5_no_rsp", rsp_valid, '0);
    tick();
    @(negedge clk); cmp("t5_orphan_one_cycle", orphan_irq_pulse, 1'b0);

    // orphan in the same cycle as a push: tag still stored
    tick(); req_valid = 4'b1000;
    @(negedge clk); cmp("t5b_grant", req_ready, 4'b1000);
    tick(); req_valid = '0; core_out_en = 1'b1;
    tick(); core_out_en = 1'b0;
    @(negedge clk); cmp("t5b_orphan", orphan_irq_pulse, 1'b1); cmp("t5b_busy", busy, 1'b1);
    tick(); core_out_en = 1'b1; core_out_data = 128'hABCD;
    tick(); core_out_en = 1'b0;
    @(negedge clk); cmp("t5b_rsp", rsp_valid, 4'b1000);

    // key_ready gating
    tick(); core_key_ready = 1'b0; req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); cmp("t6_blocked", req_ready, '0);
      tick();
    end
    core_key_ready = 1'b1;
    @(negedge clk); cmp("t6_grant_same_cycle", req_ready, 4'b0001);
    tick(); req_valid = '0;
    tick(); tick(); core_out_en = 1'b1;
    tick(); core_out_en = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
